// File: rtl/bus_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bus_pkg : shared arbiter states, slave address map, read-sel order  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package bus_pkg;

  typedef enum logic [0:0] {
    GNT_M0 = 1'b0,
    GNT_M1 = 1'b1
  } arb_state_t;

  localparam int NUM_SLV     = 4;
  localparam int REGION_SIZE = 2048;
  localparam int REGION_LSB  = $clog2(REGION_SIZE);

  localparam logic [31:0] S0_BASE = 32'h0000_0000;
  localparam logic [31:0] S1_BASE = 32'h0000_0800;
  localparam logic [31:0] S2_BASE = 32'h0000_1000;
  localparam logic [31:0] S3_BASE = 32'h0000_1800;

  // rdata_sel is ordered {S0,S1,S2,S3}, so S0 occupies the MSB
  localparam int RSEL_S0 = 3;
  localparam int RSEL_S1 = 2;
  localparam int RSEL_S2 = 1;
  localparam int RSEL_S3 = 0;

  function automatic logic [31:0] slv_base(input int idx);
    case (idx)
      0:       return S0_BASE;
      1:       return S1_BASE;
      2:       return S2_BASE;
      default: return S3_BASE;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/bus_addr_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bus_addr_decoder : combinational region decode, page bits -> 1-hot |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module bus_addr_decoder
  import bus_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic [ADDR_W-1:REGION_LSB] addr_hi,
  input  logic                       valid,
  output logic [NUM_SLV-1:0]         sel
);

  localparam int PAGE_W = ADDR_W - REGION_LSB;

  // Every bit above the region offset must match, so out-of-map pages select nothing
  for (genvar i = 0; i < NUM_SLV; i++) begin : g_slave
    localparam logic [PAGE_W-1:0] PAGE = PAGE_W'(slv_base(i) >> REGION_LSB);
    assign sel[i] = valid && (addr_hi == PAGE);
  end

endmodule
`default_nettype wire

// File: rtl/bus_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bus_ctrl : 2-master arbiter, write-path mux, slave decode and      |
// |            registered read-mux select. Option: BUS_CTRL_FAIR_EN    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module bus_ctrl
  import bus_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int FAIR_LIMIT = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              m0_req,
  input  logic              m1_req,
  input  logic              m0_wr,
  input  logic              m1_wr,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m0_grant,
  output logic              m1_grant,
  output logic [ADDR_W-1:0] s_addr,
  output logic              s_wr,
  output logic [DATA_W-1:0] s_wdata,
  output logic              s0_sel,
  output logic              s1_sel,
  output logic              s2_sel,
  output logic              s3_sel,
  output logic [3:0]        rdata_sel
);

  arb_state_t         r_state;
  arb_state_t         w_state_nxt;
  logic               w_fair_hit;
  logic               w_gnt_req;
  logic               w_gnt_wr;
  logic [NUM_SLV-1:0] w_sel;
  logic [3:0]         w_rsel_nxt;
  logic [3:0]         r_rdata_sel;

`ifdef BUS_CTRL_FAIR_EN
  localparam int               CNT_W   = (FAIR_LIMIT > 2) ? $clog2(FAIR_LIMIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FAIR_LIMIT - 1);

  logic             w_contested;
  logic [CNT_W-1:0] r_fair_cnt;

  assign w_contested = m0_req && m1_req;
  assign w_fair_hit  = w_contested && (r_fair_cnt == CNT_MAX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fair_cnt <= '0;
    end else if ((w_state_nxt != r_state) || !w_contested) begin
      r_fair_cnt <= '0;
    end else begin
      r_fair_cnt <= r_fair_cnt + 1'b1;
    end
  end
`else
  // No limit compiled in: never forces a handover
  assign w_fair_hit = (FAIR_LIMIT < 0);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= GNT_M0;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      GNT_M0:  if ((!m0_req && m1_req) || w_fair_hit) w_state_nxt = GNT_M1;
      GNT_M1:  if (!m1_req || w_fair_hit)             w_state_nxt = GNT_M0;
      default: w_state_nxt = GNT_M0;
    endcase
  end

  assign m0_grant = (r_state == GNT_M0);
  assign m1_grant = (r_state == GNT_M1);

  assign w_gnt_req = m1_grant ? m1_req   : m0_req;
  assign w_gnt_wr  = m1_grant ? m1_wr    : m0_wr;
  assign s_addr    = m1_grant ? m1_addr  : m0_addr;
  assign s_wdata   = m1_grant ? m1_wdata : m0_wdata;
  assign s_wr      = w_gnt_wr & w_gnt_req;

  bus_addr_decoder #(
    .ADDR_W (ADDR_W)
  ) u_dec (
    .addr_hi (s_addr[ADDR_W-1:REGION_LSB]),
    .valid   (w_gnt_req),
    .sel     (w_sel)
  );

  assign s0_sel = w_sel[0];
  assign s1_sel = w_sel[1];
  assign s2_sel = w_sel[2];
  assign s3_sel = w_sel[3];

  // Only reads open a data phase; writes, idle and unmapped cycles park the mux
  always_comb begin
    w_rsel_nxt          = '0;
    w_rsel_nxt[RSEL_S0] = w_sel[0] & ~s_wr;
    w_rsel_nxt[RSEL_S1] = w_sel[1] & ~s_wr;
    w_rsel_nxt[RSEL_S2] = w_sel[2] & ~s_wr;
    w_rsel_nxt[RSEL_S3] = w_sel[3] & ~s_wr;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rdata_sel <= '0;
    end else begin
      r_rdata_sel <= w_rsel_nxt;
    end
  end

  assign rdata_sel = r_rdata_sel;

endmodule
`default_nettype wire

// File: tb/tb_bus_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_bus_ctrl : directed self-checking bench for bus_ctrl            |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_bus_ctrl;

  localparam int ADDR_W     = 16;
  localparam int DATA_W     = 32;
  localparam int FAIR_LIMIT = 16;
`ifdef BUS_CTRL_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              m0_req = 1'b0, m1_req = 1'b0;
  logic              m0_wr = 1'b0, m1_wr = 1'b0;
  logic [ADDR_W-1:0] m0_addr = '0, m1_addr = '0;
  logic [DATA_W-1:0] m0_wdata = '0, m1_wdata = '0;
  logic              m0_grant, m1_grant, s_wr;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_wdata;
  logic              s0_sel, s1_sel, s2_sel, s3_sel;
  logic [3:0]        rdata_sel;
  logic [3:0]        sels;

  int n_cmp = 0;
  int n_err = 0;

  assign sels = {s0_sel, s1_sel, s2_sel, s3_sel};

  bus_ctrl #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .FAIR_LIMIT (FAIR_LIMIT)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .m0_req    (m0_req),
    .m1_req    (m1_req),
    .m0_wr     (m0_wr),
    .m1_wr     (m1_wr),
    .m0_addr   (m0_addr),
    .m1_addr   (m1_addr),
    .m0_wdata  (m0_wdata),
    .m1_wdata  (m1_wdata),
    .m0_grant  (m0_grant),
    .m1_grant  (m1_grant),
    .s_addr    (s_addr),
    .s_wr      (s_wr),
    .s_wdata   (s_wdata),
    .s0_sel    (s0_sel),
    .s1_sel    (s1_sel),
    .s2_sel    (s2_sel),
    .s3_sel    (s3_sel),
    .rdata_sel (rdata_sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic exp_m0;

    #12;
    chk("rst_m0_grant", m0_grant, 1);
    chk("rst_m1_grant", m1_grant, 0);
    chk("rst_sels", sels, 4'b0000);
    chk("rst_rdata_sel", rdata_sel, 4'b0000);
    reset_n = 1'b1;

    // M0 read in S1
    m0_req = 1'b1; m0_wr = 1'b0; m0_addr = 16'h0804; #1;
    chk("rd_s1_sels", sels, 4'b0100);
    chk("rd_s1_addr", s_addr, 16'h0804);
    chk("rd_s1_wr", s_wr, 0);
    tick();
    chk("rd_s1_rsel", rdata_sel, 4'b0100);
    m0_req = 1'b0; #1;
    chk("rd_s1_idle_sels", sels, 4'b0000);
    tick();
    chk("rd_s1_rsel_clr", rdata_sel, 4'b0000);

    // M0 write in S2
    m0_req = 1'b1; m0_wr = 1'b1; m0_addr = 16'h1004; m0_wdata = 32'hDEADBEEF; #1;
    chk("wr_s2_sels", sels, 4'b0010);
    chk("wr_s2_wr", s_wr, 1);
    chk("wr_s2_wdata", s_wdata, 32'hDEADBEEF);
    tick();
    chk("wr_s2_rsel", rdata_sel, 4'b0000);

    // unmapped read
    m0_wr = 1'b0; m0_addr = 16'h2000; #1;
    chk("unmap_sels", sels, 4'b0000);
    tick();
    chk("unmap_rsel", rdata_sel, 4'b0000);

    // back-to-back reads across the S0/S1 boundary
    m0_addr = 16'h07FF; #1;
    chk("b2b_s0_sels", sels, 4'b1000);
    tick();
    chk("b2b_s0_rsel", rdata_sel, 4'b1000);
    m0_addr = 16'h0800; #1;
    chk("b2b_s1_sels", sels, 4'b0100);
    tick();
    chk("b2b_s1_rsel", rdata_sel, 4'b0100);
    m0_req = 1'b0;
    tick();
    chk("b2b_rsel_clr", rdata_sel, 4'b0000);

    // both masters request from reset; M0 owns, then releases
    reset_n = 1'b0;
    m0_req = 1'b1; m1_req = 1'b1; m0_addr = 16'h0000; m1_addr = 16'h1FFC;
    #1 reset_n = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      chk("arb_hold_m0", m0_grant, 1);
      tick();
    end
    m0_req = 1'b0; #1;
    chk("arb_drop_m0_grant", m0_grant, 1);
    chk("arb_drop_sels", sels, 4'b0000);
    tick();
    chk("arb_m1_grant", m1_grant, 1);
    chk("arb_m0_grant_off", m0_grant, 0);
    chk("arb_m1_sels", sels, 4'b0001);
    chk("arb_m1_addr", s_addr, 16'h1FFC);
    tick();
    chk("arb_m1_rsel", rdata_sel, 4'b0001);

    // handover back to M0 keeps M1's in-flight select
    m1_req = 1'b0; m0_req = 1'b1; #1;
    chk("sw_rsel_hold", rdata_sel, 4'b0001);
    chk("sw_sels_idle", sels, 4'b0000);
    tick();
    chk("sw_m0_grant", m0_grant, 1);
    chk("sw_rsel_idle", rdata_sel, 4'b0000);
    chk("sw_m0_sels", sels, 4'b1000);
    tick();
    chk("sw_m0_rsel", rdata_sel, 4'b1000);

    // continuous contention for 40 cycles
    reset_n = 1'b0;
    m0_req = 1'b1; m1_req = 1'b1;
    #1 reset_n = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      exp_m0 = FAIR ? ((((k - 1) / FAIR_LIMIT) % 2) == 0) : 1'b1;
      chk("fair_m0_grant", m0_grant, exp_m0);
      chk("fair_m1_grant", m1_grant, !exp_m0);
      tick();
    end

    // reset while a read is in flight
    m0_req = 1'b0; m1_req = 1'b1; m1_wr = 1'b0; m1_addr = 16'h0804;
    tick();
    chk("rstmid_m1_grant", m1_grant, 1);
    chk("rstmid_sels", sels, 4'b0100);
    tick();
    chk("rstmid_rsel", rdata_sel, 4'b0100);
    #1 reset_n = 1'b0;
    #1;
    chk("rstmid_rsel_clr", rdata_sel, 4'b0000);
    chk("rstmid_m0_grant", m0_grant, 1);
    chk("rstmid_m1_grant", m1_grant, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
